// File: rtl/kyber_pkg.sv
// Shared Kyber constants, butterfly mode encodings and modular helpers.
// Helpers take operands already in [0,q-1].
package kyber_pkg;

    localparam int unsigned KQ   = 3329;
    localparam int unsigned KWID = 12;

    typedef enum logic [1:0] {
        BF_NTT  = 2'b00,
        BF_INTT = 2'b01,
        BF_BYP  = 2'b10,
        BF_MUL  = 2'b11
    } bf_mode_t;

    // Barrett multiplier floor(2^(2*wid) / q); the quotient estimate is then off by at most one.
    function automatic longint unsigned barrett_mu(input int unsigned q, input int unsigned wid);
        return (64'd1 << (2 * wid)) / 64'(q);
    endfunction

    function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                            input int unsigned q);
        int unsigned s;
        s = a + b;
        return (s >= q) ? s - q : s;
    endfunction

    function automatic int unsigned mod_sub(input int unsigned a, input int unsigned b,
                                            input int unsigned q);
        return (a >= b) ? a - b : a + q - b;
    endfunction

endpackage

// File: rtl/bf_lane.sv
// Single-lane modular butterfly datapath (NTT/INTT/BYPASS/MUL).
// Latency 4 cycles; all stages advance together on en, hold otherwise.
// No handshake of its own: the parent drives en from its valid/ready logic.
module bf_lane
    import kyber_pkg::*;
#(
    parameter int unsigned     WID = KWID,
    parameter int unsigned     Q   = KQ,
    parameter longint unsigned MU  = barrett_mu(KQ, KWID)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  bf_mode_t       mode,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    input  logic [WID-1:0] w,
    output logic [WID-1:0] c,
    output logic [WID-1:0] d
);

    localparam int unsigned       PW   = 2 * WID;
    localparam logic [2*PW-1:0]   MU_W = (2*PW)'(MU);
    localparam logic [PW-1:0]     Q_P  = PW'(Q);

    function automatic logic [WID-1:0] barrett(input logic [PW-1:0] x);
        logic [2*PW-1:0] prod;
        logic [PW-1:0]   qe;
        logic [PW-1:0]   r;
        prod = (2*PW)'(x) * MU_W;
        qe   = prod[PW +: PW];
        r    = x - qe * Q_P;
        if (r >= Q_P) r = r - Q_P;
        return WID'(r);
    endfunction

    logic [WID-1:0] s1_x_n, s1_y_n, m0_n;
    logic [WID-1:0] s1_x, s1_y, s1_w;
    logic [PW-1:0]  s2_p0, s2_p1;
    logic [WID-1:0] s2_x, s2_y, s3_x, s3_y, s3_r0, s3_r1;
    logic [WID-1:0] c_n, d_n;
    bf_mode_t       s1_mode, s2_mode, s3_mode;

    always_comb begin
        s1_x_n = a;
        s1_y_n = b;
        if (mode == BF_INTT) begin
            s1_x_n = WID'(mod_add(32'(a), 32'(b), Q));
            s1_y_n = WID'(mod_sub(32'(a), 32'(b), Q));
        end
    end

    // Multiplier 0 takes b (NTT), a-b (INTT) or a (MUL); multiplier 1 only matters for MUL.
    assign m0_n = (s1_mode == BF_MUL) ? s1_x : s1_y;

    always_comb begin
        c_n = s3_x;
        d_n = s3_y;
        case (s3_mode)
            BF_NTT: begin
                c_n = WID'(mod_add(32'(s3_x), 32'(s3_r0), Q));
                d_n = WID'(mod_sub(32'(s3_x), 32'(s3_r0), Q));
            end
            BF_INTT: d_n = s3_r0;
            BF_MUL: begin
                c_n = s3_r0;
                d_n = s3_r1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_x <= '0;  s1_y <= '0;  s1_w <= '0;  s1_mode <= BF_NTT;
            s2_p0 <= '0; s2_p1 <= '0; s2_x <= '0; s2_y <= '0; s2_mode <= BF_NTT;
            s3_r0 <= '0; s3_r1 <= '0; s3_x <= '0; s3_y <= '0; s3_mode <= BF_NTT;
            c <= '0;
            d <= '0;
        end else if (en) begin
            s1_x    <= s1_x_n;
            s1_y    <= s1_y_n;
            s1_w    <= w;
            s1_mode <= mode;
            s2_p0   <= PW'(m0_n) * PW'(s1_w);
            s2_p1   <= PW'(s1_y) * PW'(s1_w);
            s2_x    <= s1_x;
            s2_y    <= s1_y;
            s2_mode <= s1_mode;
            s3_r0   <= barrett(s2_p0);
            s3_r1   <= barrett(s2_p1);
            s3_x    <= s2_x;
            s3_y    <= s2_y;
            s3_mode <= s2_mode;
            c       <= c_n;
            d       <= d_n;
        end
    end

endmodule

// File: rtl/bf_pipe_array.sv
// LANES parallel modular butterflies behind one elastic valid/ready pipeline.
// Latency 4 cycles, one beat per cycle when out_ready stays high.
// Whole pipe stalls only while the output register holds an unaccepted beat.
module bf_pipe_array
    import kyber_pkg::*;
#(
    parameter int unsigned WID   = KWID,
    parameter int unsigned Q     = KQ,
    parameter int unsigned LANES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic                 in_last,
    input  logic [LANES*WID-1:0] in_a,
    input  logic [LANES*WID-1:0] in_b,
    input  logic [LANES*WID-1:0] in_w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [LANES*WID-1:0] out_c,
    output logic [LANES*WID-1:0] out_d
);

    localparam int unsigned     LAT = 4;
    localparam longint unsigned MU  = barrett_mu(Q, WID);

    logic [LAT-1:0] vld;
    logic [LAT-1:0] lst;
    logic           adv;

    assign adv       = ~vld[LAT-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[LAT-1];
    assign out_last  = lst[LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            lst <= '0;
        end else if (adv) begin
            vld <= {vld[LAT-2:0], in_valid};
            lst <= {lst[LAT-2:0], in_last};
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bf_lane #(
            .WID (WID),
            .Q   (Q),
            .MU  (MU)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .en   (adv),
            .mode (bf_mode_t'(in_mode)),
            .a    (in_a[g*WID +: WID]),
            .b    (in_b[g*WID +: WID]),
            .w    (in_w[g*WID +: WID]),
            .c    (out_c[g*WID +: WID]),
            .d    (out_d[g*WID +: WID])
        );
    end

endmodule

// File: tb/tb_bf_pipe_array.sv
// Bench for bf_pipe_array: directed vectors, handshake timing, reset, and a
// random valid/ready run scored against a plain mod-Q arithmetic model.
module tb_bf_pipe_array;

    localparam int WID   = 12;
    localparam int Q     = 3329;
    localparam int LANES = 2;
    localparam int W     = LANES * WID;

    typedef struct packed {
        logic [1:0]   mode;
        logic         last;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] w;
    } stim_t;

    typedef struct packed {
        logic [W-1:0] c;
        logic [W-1:0] d;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [1:0]   in_mode = 2'b00;
    logic [W-1:0] in_a = '0, in_b = '0, in_w = '0;
    logic         out_valid, out_ready = 1'b0, out_last;
    logic [W-1:0] out_c, out_d;

    int           total = 0, bad = 0;
    int           emitted = 0, acc_n = 0;
    beat_t        exp_q[$];
    logic         hold_chk = 1'b0, held_last;
    logic [W-1:0] held_c, held_d;
    logic         vld_s, rdy_s, acc_s;
    logic [W-1:0] obs_c, obs_d;

    always #5 clk = ~clk;

    bf_pipe_array #(.WID(WID), .Q(Q), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_c     (out_c),
        .out_d     (out_d)
    );

    function automatic void lane_ref(input int mode, input int a, input int b, input int w,
                                     output int c, output int d);
        case (mode)
            0:       begin c = (a + w * b) % Q; d = ((a - w * b) % Q + Q) % Q; end
            1:       begin c = (a + b) % Q;     d = (((a - b) * w) % Q + Q) % Q; end
            2:       begin c = a;               d = b; end
            default: begin c = (a * w) % Q;     d = (b * w) % Q; end
        endcase
    endfunction

    function automatic beat_t model(input stim_t s);
        beat_t r;
        int    c, d;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_ref(int'(s.mode), int'(s.a[l*WID +: WID]), int'(s.b[l*WID +: WID]),
                     int'(s.w[l*WID +: WID]), c, d);
            r.c[l*WID +: WID] = WID'(c);
            r.d[l*WID +: WID] = WID'(d);
        end
        r.last = s.last;
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) v[l*WID +: WID] = WID'($urandom_range(0, Q - 1));
        return v;
    endfunction

    function automatic stim_t rnd_stim(input int mode, input logic last);
        stim_t s;
        s.mode = 2'(mode);
        s.last = last;
        s.a    = rnd_vec();
        s.b    = rnd_vec();
        s.w    = rnd_vec();
        return s;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input stim_t s, input logic v, input logic ordy);
        in_valid  = v;
        in_mode   = s.mode;
        in_last   = s.last;
        in_a      = s.a;
        in_b      = s.b;
        in_w      = s.w;
        out_ready = ordy;
    endtask

    // Samples one cycle mid-period, scores emitted beats, then advances to the next negedge.
    task automatic tick();
        stim_t cur;
        beat_t e;
        #1;
        vld_s = out_valid;
        rdy_s = in_ready;
        acc_s = in_valid && in_ready;
        obs_c = out_c;
        obs_d = out_d;
        if (hold_chk) begin
            chk("hold_vld", W'(out_valid), W'(1'b1));
            chk("hold_c", out_c, held_c);
            chk("hold_d", out_d, held_d);
            chk("hold_last", W'(out_last), W'(held_last));
        end
        if (out_valid && out_ready) begin
            emitted++;
            if (exp_q.size() == 0) begin
                chk("spurious_beat", W'(out_valid), '0);
            end else begin
                e = exp_q.pop_front();
                chk("out_c", out_c, e.c);
                chk("out_d", out_d, e.d);
                chk("out_last", W'(out_last), W'(e.last));
            end
        end
        if (acc_s) begin
            cur.mode = in_mode;
            cur.last = in_last;
            cur.a    = in_a;
            cur.b    = in_b;
            cur.w    = in_w;
            exp_q.push_back(model(cur));
            acc_n++;
        end
        hold_chk  = out_valid && !out_ready;
        held_c    = out_c;
        held_d    = out_d;
        held_last = out_last;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_empty", W'(exp_q.size()), '0);
    endtask

    task automatic single(input string tag, input int mode, input int a, input int b,
                          input int w, input int ec, input int ed);
        stim_t s;
        s.mode = 2'(mode);
        s.last = 1'b1;
        s.a    = {LANES{WID'(a)}};
        s.b    = {LANES{WID'(b)}};
        s.w    = {LANES{WID'(w)}};
        drive(s, 1'b1, 1'b1);
        tick();
        drive(s, 1'b0, 1'b1);
        repeat (4) tick();
        chk({tag, "_vld"}, W'(vld_s), W'(1'b1));
        chk({tag, "_c"}, obs_c, {LANES{WID'(ec)}});
        chk({tag, "_d"}, obs_d, {LANES{WID'(ed)}});
    endtask

    initial begin
        stim_t s;
        stim_t st[8];
        int    k, sent, n, e0, a0;

        repeat (2) @(negedge clk);
        chk("rst_vld", W'(out_valid), '0);
        chk("rst_c", out_c, '0);
        chk("rst_d", out_d, '0);
        chk("rst_last", W'(out_last), '0);
        chk("rst_rdy", W'(in_ready), W'(1'b1));
        rst = 1'b1;
        @(negedge clk);

        // NTT with distinct lanes, including the all-(Q-1) corner.
        s.mode = 2'd0;
        s.last = 1'b0;
        s.a    = {12'd3328, 12'd1};
        s.b    = {12'd3328, 12'd2};
        s.w    = {12'd3328, 12'd17};
        drive(s, 1'b1, 1'b1);
        tick();
        drive(s, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("ntt_latency", W'(vld_s), W'(i == 4));
        end
        chk("ntt_c", obs_c, {12'd0, 12'd35});
        chk("ntt_d", obs_d, {12'd3327, 12'd3296});

        single("intt", 1, 5, 10, 17, 15, 3244);
        single("byp", 2, 100, 200, 1234, 100, 200);
        single("mul", 3, 3328, 2, 3303, 26, 3277);

        // Eight back-to-back beats cycling modes; last only on the eighth.
        for (int i = 0; i < 8; i++) st[i] = rnd_stim(i % 4, i == 7);
        for (int i = 0; i < 16; i++) begin
            if (i < 8) drive(st[i], 1'b1, 1'b1);
            else       drive(st[0], 1'b0, 1'b1);
            tick();
            if (i >= 1) chk("mix_vld_run", W'(vld_s), W'(i >= 4 && i <= 11));
        end
        drain(20);

        // Backpressure: sink stalls 3 cycles from the first out_valid.
        for (int i = 0; i < 6; i++) st[i] = rnd_stim($urandom_range(0, 3), i == 5);
        e0 = emitted;
        k  = 0;
        for (int i = 0; i < 12; i++) begin
            drive(st[k % 6], k < 6, !(i >= 4 && i <= 6));
            tick();
            chk("bp_in_ready", W'(rdy_s), W'(!(i >= 4 && i <= 6)));
            if (acc_s) k++;
        end
        drain(20);
        chk("bp_delivered", W'(emitted - e0), W'(6));

        // Reset with three beats in flight and one on the output.
        for (int i = 0; i < 4; i++) begin
            drive(rnd_stim($urandom_range(0, 3), 1'b0), 1'b1, 1'b1);
            tick();
        end
        rst = 1'b0;
        #1;
        chk("mid_rst_vld", W'(out_valid), '0);
        chk("mid_rst_c", out_c, '0);
        chk("mid_rst_d", out_d, '0);
        chk("mid_rst_last", W'(out_last), '0);
        chk("mid_rst_rdy", W'(in_ready), W'(1'b1));
        exp_q.delete();
        hold_chk = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        s = rnd_stim(3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(s, i == 0, 1'b1);
            tick();
            chk("post_rst_vld", W'(vld_s), W'(i == 4));
        end

        // Random operands, modes and handshakes.
        e0   = emitted;
        a0   = acc_n;
        sent = 0;
        n    = 0;
        while (sent < 10000 && n < 60000) begin
            drive(rnd_stim($urandom_range(0, 3), 1'($urandom_range(0, 1))),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
            tick();
            if (acc_s) sent++;
            n++;
        end
        chk("rnd_sent", W'(sent), W'(10000));
        drain(100);
        chk("rnd_conserve", W'(emitted - e0), W'(acc_n - a0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
